// File: rtl/uint_muler_pkg.sv
// Shared definitions for the radix-2 shift-add multiplier: default widths,
// RISC-V M-extension op encodings, FSM states and operand-signedness helpers.
package uint_muler_pkg;

  localparam int MUL_DATAWIDTH  = 32;
  localparam int MUL_STEPS_LOG2 = 5;

  typedef enum logic [1:0] {
    OP_MUL    = 2'b00,
    OP_MULH   = 2'b01,
    OP_MULHSU = 2'b10,
    OP_MULHU  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_CALC = 2'b01,
    S_FIX  = 2'b10,
    S_DONE = 2'b11
  } state_e;

  // rs1 is signed for MULH and MULHSU
  function automatic logic a_is_signed(input logic [1:0] op);
    return (op == OP_MULH) || (op == OP_MULHSU);
  endfunction

  // rs2 is signed for MULH only
  function automatic logic b_is_signed(input logic [1:0] op);
    return (op == OP_MULH);
  endfunction

endpackage

// File: rtl/uint_muler_adder.sv
// Plain W-bit ripple adder with carry in/out, used for the per-step partial add.
module uint_muler_adder #(
  parameter int W = 32
) (
  input  logic [W-1:0] data_a,
  input  logic [W-1:0] data_b,
  input  logic         ci,
  output logic [W-1:0] result,
  output logic         co
);

  assign {co, result} = {1'b0, data_a} + {1'b0, data_b} + {{W{1'b0}}, ci};

endmodule

// File: rtl/uint_muler.sv
// Sequential radix-2 shift-add multiplier. Operands are converted to
// magnitudes on accept, multiplied unsigned one bit per clock, and the sign
// is re-applied in a single fix-up cycle before the done pulse.
module uint_muler
  import uint_muler_pkg::*;
#(
  parameter int DATAWIDTH  = MUL_DATAWIDTH,
  parameter int STEPS_LOG2 = MUL_STEPS_LOG2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   flush,
  input  logic [1:0]             op,
  input  logic [DATAWIDTH-1:0]   multiplicand,
  input  logic [DATAWIDTH-1:0]   multiplier,
  output logic                   busy,
  output logic                   done,
  output logic [2*DATAWIDTH-1:0] product,
  output logic [DATAWIDTH-1:0]   result
);

  localparam int W = DATAWIDTH;
  localparam logic [STEPS_LOG2-1:0] CNT_LAST = STEPS_LOG2'(W - 1);
  localparam logic [STEPS_LOG2-1:0] CNT_ONE  = {{(STEPS_LOG2-1){1'b0}}, 1'b1};
  localparam logic [W-1:0]          ONE_W    = {{(W-1){1'b0}}, 1'b1};
  localparam logic [2*W-1:0]        ONE_2W   = {{(2*W-1){1'b0}}, 1'b1};

  state_e                state_r;
  state_e                state_nxt_s;
  logic [STEPS_LOG2-1:0] cnt_r;
  logic [2*W-1:0]        acc_r;      // {hi, lo}
  logic [W-1:0]          mcand_r;    // |A|
  logic                  neg_r;
  logic [1:0]            op_r;
  logic [2*W-1:0]        product_r;
  logic [W-1:0]          result_r;
  logic                  busy_r;
  logic                  done_r;
  logic                  busy_nxt_s;
  logic                  done_nxt_s;

  logic                  accept_s;
  logic                  sign_a_s;
  logic                  sign_b_s;
  logic [W-1:0]          abs_a_s;
  logic [W-1:0]          abs_b_s;
  logic [W-1:0]          hi_s;
  logic [W-1:0]          lo_s;
  logic [W-1:0]          addend_s;
  logic [W-1:0]          sum_s;
  logic                  co_s;
  logic [2*W-1:0]        step_s;
  logic [2*W-1:0]        prod_fix_s;
  logic [W-1:0]          res_fix_s;

  // flush has priority over a new request in IDLE
  assign accept_s = (state_r == S_IDLE) && start && !flush;

  // Operand conditioning: magnitudes and sign of the result. The most
  // negative value negates to itself, which is its correct unsigned magnitude.
  always_comb begin
    sign_a_s = a_is_signed(op) & multiplicand[W-1];
    sign_b_s = b_is_signed(op) & multiplier[W-1];
    abs_a_s  = sign_a_s ? (~multiplicand + ONE_W) : multiplicand;
    abs_b_s  = sign_b_s ? (~multiplier + ONE_W) : multiplier;
  end

  assign hi_s     = acc_r[2*W-1:W];
  assign lo_s     = acc_r[W-1:0];
  assign addend_s = lo_s[0] ? mcand_r : {W{1'b0}};

  uint_muler_adder #(
    .W (W)
  ) u_adder (
    .data_a (hi_s),
    .data_b (addend_s),
    .ci     (1'b0),
    .result (sum_s),
    .co     (co_s)
  );

  // The carry out of the add is shifted straight into hi, so it never needs
  // to be stored between steps.
  assign step_s = {co_s, sum_s, lo_s[W-1:1]};

  // Sign fix-up and result-half selection for the FIX cycle
  always_comb begin
    prod_fix_s = neg_r ? (~acc_r + ONE_2W) : acc_r;
    res_fix_s  = (op_r == OP_MUL) ? prod_fix_s[W-1:0] : prod_fix_s[2*W-1:W];
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (accept_s) begin
          state_nxt_s = S_CALC;
        end else begin
          state_nxt_s = S_IDLE;
        end
      end
      S_CALC: begin
        if (flush) begin
          state_nxt_s = S_IDLE;
        end else if (cnt_r == CNT_LAST) begin
          state_nxt_s = S_FIX;
        end else begin
          state_nxt_s = S_CALC;
        end
      end
      S_FIX: begin
        if (flush) begin
          state_nxt_s = S_IDLE;
        end else begin
          state_nxt_s = S_DONE;
        end
      end
      S_DONE:  state_nxt_s = S_IDLE;
      default: state_nxt_s = S_IDLE;
    endcase
  end

  // FSM outputs, decoded from the next state so they can be registered
  always_comb begin
    busy_nxt_s = (state_nxt_s == S_CALC) || (state_nxt_s == S_FIX);
    done_nxt_s = (state_nxt_s == S_DONE);
  end

  // Registered status outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      busy_r <= busy_nxt_s;
      done_r <= done_nxt_s;
    end
  end

  // Datapath: operand capture, shift-add iteration and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r     <= {STEPS_LOG2{1'b0}};
      acc_r     <= {(2*W){1'b0}};
      mcand_r   <= {W{1'b0}};
      neg_r     <= 1'b0;
      op_r      <= 2'b00;
      product_r <= {(2*W){1'b0}};
      result_r  <= {W{1'b0}};
    end else begin
      case (state_r)
        S_IDLE: begin
          if (accept_s) begin
            op_r    <= op;
            mcand_r <= abs_a_s;
            neg_r   <= sign_a_s ^ sign_b_s;
            acc_r   <= {{W{1'b0}}, abs_b_s};
            cnt_r   <= {STEPS_LOG2{1'b0}};
          end else begin
            acc_r <= acc_r;
          end
        end
        S_CALC: begin
          acc_r <= step_s;
          cnt_r <= cnt_r + CNT_ONE;
        end
        S_FIX: begin
          if (!flush) begin
            product_r <= prod_fix_s;
            result_r  <= res_fix_s;
          end else begin
            product_r <= product_r;
          end
        end
        default: begin
          acc_r <= acc_r;
        end
      endcase
    end
  end

  assign busy    = busy_r;
  assign done    = done_r;
  assign product = product_r;
  assign result  = result_r;

endmodule

// File: tb/tb_uint_muler.sv
// Directed bench for uint_muler with a scoreboard of expected {product,result}.
module tb_uint_muler;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        flush = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] a = 32'd0;
  logic [31:0] b = 32'd0;
  logic        busy;
  logic        done;
  logic [63:0] product;
  logic [31:0] result;

  int checks = 0;
  int failures = 0;
  logic [95:0] sb_q[$];

  uint_muler dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .flush        (flush),
    .op           (op),
    .multiplicand (a),
    .multiplier   (b),
    .busy         (busy),
    .done         (done),
    .product      (product),
    .result       (result)
  );

  always #5 clk = ~clk;

  // reference: exact 64-bit product of the sign/zero-extended operands
  function automatic logic [95:0] model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    logic [63:0] xe;
    logic [63:0] ye;
    logic [63:0] p;
    xe = (o == 2'b01 || o == 2'b10) ? {{32{x[31]}}, x} : {32'd0, x};
    ye = (o == 2'b01) ? {{32{y[31]}}, y} : {32'd0, y};
    p  = xe * ye;
    return {p, (o == 2'b00) ? p[31:0] : p[63:32]};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // drive one request; leaves the bench at the negedge after the accept edge
  task automatic start_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                          input logic [63:0] ep, input logic [31:0] er);
    @(negedge clk);
    op = o; a = x; b = y; start = 1'b1;
    sb_q.push_back({ep, er});
    @(negedge clk);
    start = 1'b0;
    a = $urandom; b = $urandom; op = 2'($urandom_range(0, 3));
  endtask

  // wait for done, counting edges since accept and busy cycles; optional start re-pulses
  task automatic finish_op(input string tag, input int r1, input int r2);
    int cyc;
    int bc;
    bit got;
    logic [95:0] e;
    cyc = 1; bc = 0; got = 1'b0;
    while (cyc < 100) begin
      if (done) begin
        got = 1'b1;
        break;
      end
      if (busy) bc++;
      start = (cyc == r1 || cyc == r2);
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    chk({tag, "_done_seen"}, {63'd0, got}, 64'd1);
    if (got) begin
      chk({tag, "_latency"}, 64'(cyc), 64'd34);
      chk({tag, "_busy_cycles"}, 64'(bc), 64'd33);
      e = sb_q.pop_front();
      chk({tag, "_product"}, product, e[95:32]);
      chk({tag, "_result"}, {32'd0, result}, {32'd0, e[31:0]});
      @(negedge clk);
      chk({tag, "_done_pulse"}, {63'd0, done}, 64'd0);
    end
  endtask

  // confirm no done appears over n cycles
  task automatic no_done(input string tag, input int n);
    int cnt;
    cnt = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (done) cnt++;
    end
    chk({tag, "_spurious_done"}, 64'(cnt), 64'd0);
  endtask

  initial begin
    logic [63:0] prev_p;
    logic [1:0]  ro;
    logic [31:0] rx;
    logic [31:0] ry;

    // reset state
    #12;
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    chk("rst_product", product, 64'd0);
    chk("rst_result", {32'd0, result}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    start_op(2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 32'hFFFF_FFFE);
    finish_op("mulhu_max", 0, 0);

    start_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0000_0000_0000_0001, 32'h0000_0000);
    finish_op("mulh_m1", 0, 0);
    start_op(2'b01, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, 32'h4000_0000);
    finish_op("mulh_minneg", 0, 0);

    start_op(2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFF_0000_0001, 32'hFFFF_FFFF);
    finish_op("mulhsu_m1", 0, 0);
    start_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 32'h0000_0001);
    finish_op("mul_m1", 0, 0);

    // flush in the 10th CALC cycle: no done, outputs keep previous value
    prev_p = product;
    start_op(2'b11, 32'd7, 32'd9, 64'd63, 32'd0);
    void'(sb_q.pop_back());
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush_busy_drop", {63'd0, busy}, 64'd0);
    no_done("flush", 40);
    chk("flush_product_hold", product, prev_p);

    // start and flush together in IDLE: not accepted
    @(negedge clk);
    start = 1'b1; flush = 1'b1;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    chk("start_flush_busy", {63'd0, busy}, 64'd0);
    no_done("start_flush", 40);

    // zero operand with start re-pulsed mid-run: ignored, exactly one done
    start_op(2'b00, 32'h1234_5678, 32'h0000_0000, 64'd0, 32'd0);
    finish_op("mul_zero", 5, 20);
    no_done("repulse", 40);

    // a few randomised operations against the reference model
    for (int i = 0; i < 4; i++) begin
      logic [95:0] m;
      ro = 2'(i);
      rx = $urandom;
      ry = $urandom;
      m = model(ro, rx, ry);
      start_op(ro, rx, ry, m[95:32], m[31:0]);
      finish_op("rand", 0, 0);
    end

    // asynchronous reset mid-CALC
    start_op(2'b11, 32'hDEAD_BEEF, 32'h1234_5678, 64'd0, 32'd0);
    void'(sb_q.pop_back());
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", {63'd0, busy}, 64'd0);
    chk("arst_done", {63'd0, done}, 64'd0);
    chk("arst_product", product, 64'd0);
    chk("arst_result", {32'd0, result}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    start_op(2'b11, 32'd3, 32'd5, 64'd15, 32'd0);
    finish_op("post_rst", 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
